// File: rtl/noc_switch_allocator.sv
// Per-cycle switch allocator for the 5-port NoC router: round-robin arbitration per output
// with wormhole locking. Selects and grants are combinational and reach the crossbar and buffers in the same cycle.
module noc_switch_allocator #(
    parameter int                NP       = 5,
    parameter int                SELW     = 3,
    parameter logic [SELW-1:0]   IDLE_SEL = 3'd7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NP-1:0]    in_valid,
    input  logic [NP-1:0]    in_head,
    input  logic [NP-1:0]    in_tail,
    input  logic [SELW-1:0]  dest_R,
    input  logic [SELW-1:0]  dest_L,
    input  logic [SELW-1:0]  dest_U,
    input  logic [SELW-1:0]  dest_D,
    input  logic [SELW-1:0]  dest_EJ,
    input  logic [NP-1:0]    out_ready,
    output logic [SELW-1:0]  R_req,
    output logic [SELW-1:0]  L_req,
    output logic [SELW-1:0]  U_req,
    output logic [SELW-1:0]  D_req,
    output logic [SELW-1:0]  EJ_req,
    output logic [NP-1:0]    in_grant
);

    // Port index addition modulo NP; both operands are always below NP.
    function automatic logic [SELW-1:0] wrap_add(input logic [SELW-1:0] base,
                                                 input logic [SELW-1:0] off);
        logic [SELW:0] sum;
        sum = {1'b0, base} + {1'b0, off};
        if (sum >= (SELW+1)'(NP)) begin
            sum = sum - (SELW+1)'(NP);
        end else begin
            sum = sum;
        end
        return sum[SELW-1:0];
    endfunction

    logic [SELW-1:0] dest_s       [NP];
    logic [NP-1:0]   req_s        [NP];   // req_s[o][i]: input i wants output o
    logic [NP-1:0]   lock_valid_r;
    logic [SELW-1:0] lock_owner_r [NP];
    logic [SELW-1:0] rr_ptr_r     [NP];
    logic [NP-1:0]   win_s;
    logic [SELW-1:0] win_idx_s    [NP];
    logic [SELW-1:0] sel_s        [NP];
    logic [NP-1:0]   grant_s;
    logic [SELW-1:0] cand_s;
    logic            found_s;

    assign dest_s[0] = dest_R;
    assign dest_s[1] = dest_L;
    assign dest_s[2] = dest_U;
    assign dest_s[3] = dest_D;
    assign dest_s[4] = dest_EJ;

    // Request matrix; destinations 5..7 never match a port and so never request.
    always_comb begin
        for (int o = 0; o < NP; o++) begin
            req_s[o] = '0;
            for (int i = 0; i < NP; i++) begin
                req_s[o][i] = in_valid[i] & (dest_s[i] == SELW'(o));
            end
        end
    end

    // Per-output arbitration: locked outputs serve only their owner, unlocked ones scan heads from rr_ptr.
    always_comb begin
        cand_s  = '0;
        found_s = 1'b0;
        for (int o = 0; o < NP; o++) begin
            win_s[o]     = 1'b0;
            win_idx_s[o] = IDLE_SEL;
            if (lock_valid_r[o]) begin
                if (out_ready[o] && req_s[o][lock_owner_r[o]]) begin
                    win_s[o]     = 1'b1;
                    win_idx_s[o] = lock_owner_r[o];
                end else begin
                    win_s[o]     = 1'b0;
                end
            end else begin
                found_s = 1'b0;
                for (int k = 0; k < NP; k++) begin
                    cand_s = wrap_add(rr_ptr_r[o], SELW'(k));
                    if (!found_s && out_ready[o] && req_s[o][cand_s] && in_head[cand_s]) begin
                        found_s      = 1'b1;
                        win_s[o]     = 1'b1;
                        win_idx_s[o] = cand_s;
                    end else begin
                        found_s      = found_s;
                    end
                end
            end
        end
    end

    // Crossbar selects and buffer pops, forced idle while reset is asserted.
    always_comb begin
        grant_s = '0;
        for (int o = 0; o < NP; o++) begin
            sel_s[o] = IDLE_SEL;
        end
        if (rst_n) begin
            for (int o = 0; o < NP; o++) begin
                if (win_s[o]) begin
                    sel_s[o]                = win_idx_s[o];
                    grant_s[win_idx_s[o]]   = 1'b1;
                end else begin
                    sel_s[o]                = IDLE_SEL;
                end
            end
        end else begin
            grant_s = '0;
        end
    end

    assign R_req    = sel_s[0];
    assign L_req    = sel_s[1];
    assign U_req    = sel_s[2];
    assign D_req    = sel_s[3];
    assign EJ_req   = sel_s[4];
    assign in_grant = grant_s;

    // Lock and round-robin pointer update; the pointer only moves on head grants to unlocked outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int o = 0; o < NP; o++) begin
                lock_valid_r[o] <= 1'b0;
                lock_owner_r[o] <= '0;
                rr_ptr_r[o]     <= '0;
            end
        end else begin
            for (int o = 0; o < NP; o++) begin
                if (win_s[o]) begin
                    if (lock_valid_r[o]) begin
                        if (in_tail[win_idx_s[o]]) begin
                            lock_valid_r[o] <= 1'b0;
                        end
                    end else begin
                        rr_ptr_r[o] <= wrap_add(win_idx_s[o], SELW'(1));
                        if (!in_tail[win_idx_s[o]]) begin
                            lock_valid_r[o] <= 1'b1;
                            lock_owner_r[o] <= win_idx_s[o];
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_noc_switch_allocator.sv
// Directed bench for noc_switch_allocator: hand-computed selects and grants checked
// with immediate assertions half a cycle away from the active clock edge.
module tb_noc_switch_allocator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] in_valid, in_head, in_tail, out_ready;
    logic [2:0] dest_R, dest_L, dest_U, dest_D, dest_EJ;
    logic [2:0] R_req, L_req, U_req, D_req, EJ_req;
    logic [4:0] in_grant;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    noc_switch_allocator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_head   (in_head),
        .in_tail   (in_tail),
        .dest_R    (dest_R),
        .dest_L    (dest_L),
        .dest_U    (dest_U),
        .dest_D    (dest_D),
        .dest_EJ   (dest_EJ),
        .out_ready (out_ready),
        .R_req     (R_req),
        .L_req     (L_req),
        .U_req     (U_req),
        .D_req     (D_req),
        .EJ_req    (EJ_req),
        .in_grant  (in_grant)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] r, input logic [2:0] l,
                             input logic [2:0] u, input logic [2:0] d, input logic [2:0] ej,
                             input logic [4:0] g);
        check({tag, "_R_req"},  {5'd0, R_req},    {5'd0, r});
        check({tag, "_L_req"},  {5'd0, L_req},    {5'd0, l});
        check({tag, "_U_req"},  {5'd0, U_req},    {5'd0, u});
        check({tag, "_D_req"},  {5'd0, D_req},    {5'd0, d});
        check({tag, "_EJ_req"}, {5'd0, EJ_req},   {5'd0, ej});
        check({tag, "_grant"},  {3'd0, in_grant}, {3'd0, g});
    endtask

    task automatic drive(input logic [4:0] v, input logic [4:0] h, input logic [4:0] t,
                         input logic [2:0] dr, input logic [2:0] dl, input logic [2:0] du,
                         input logic [2:0] dd, input logic [2:0] dej, input logic [4:0] rdy);
        in_valid  = v;
        in_head   = h;
        in_tail   = t;
        dest_R    = dr;
        dest_L    = dl;
        dest_U    = du;
        dest_D    = dd;
        dest_EJ   = dej;
        out_ready = rdy;
    endtask

    initial begin
        // Reset held with every input requesting R.
        rst_n = 1'b0;
        drive(5'b11111, 5'b11111, 5'b11111, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 5'b11111);
        #2;
        check_all("reset", 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 5'b00000);
        @(negedge clk);
        drive(5'b00000, 5'b00000, 5'b00000, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 5'b11111);
        rst_n = 1'b1;
        #1;
        check_all("idle", 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 5'b00000);

        // Contention: L, U, D single-flit packets to R.
        @(negedge clk);
        drive(5'b01110, 5'b11111, 5'b11111, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 5'b11111);
        #1; check_all("rr1", 3'd1, 3'd7, 3'd7, 3'd7, 3'd7, 5'b00010);
        @(negedge clk); #1; check_all("rr2", 3'd2, 3'd7, 3'd7, 3'd7, 3'd7, 5'b00100);
        @(negedge clk); #1; check_all("rr3", 3'd3, 3'd7, 3'd7, 3'd7, 3'd7, 5'b01000);
        @(negedge clk); #1; check_all("rr4", 3'd1, 3'd7, 3'd7, 3'd7, 3'd7, 5'b00010);

        // Wormhole: U head/body/body/tail to EJ; R joins with a head after the lock is taken.
        @(negedge clk);
        drive(5'b00100, 5'b00100, 5'b00000, 3'd4, 3'd0, 3'd4, 3'd0, 3'd0, 5'b11111);
        #1; check_all("wh_head", 3'd7, 3'd7, 3'd7, 3'd7, 3'd2, 5'b00100);
        @(negedge clk);
        drive(5'b00101, 5'b00001, 5'b00001, 3'd4, 3'd0, 3'd4, 3'd0, 3'd0, 5'b11111);
        #1; check_all("wh_body1", 3'd7, 3'd7, 3'd7, 3'd7, 3'd2, 5'b00100);
        @(negedge clk); #1; check_all("wh_body2", 3'd7, 3'd7, 3'd7, 3'd7, 3'd2, 5'b00100);
        @(negedge clk);
        drive(5'b00101, 5'b00001, 5'b00101, 3'd4, 3'd0, 3'd4, 3'd0, 3'd0, 5'b11111);
        #1; check_all("wh_tail", 3'd7, 3'd7, 3'd7, 3'd7, 3'd2, 5'b00100);
        @(negedge clk);
        drive(5'b00001, 5'b00001, 5'b00001, 3'd4, 3'd0, 3'd4, 3'd0, 3'd0, 5'b11111);
        #1; check_all("wh_next", 3'd7, 3'd7, 3'd7, 3'd7, 3'd0, 5'b00001);

        // Backpressure: U locks D, D stalls two cycles while EJ waits with a head for D.
        @(negedge clk);
        drive(5'b00100, 5'b00100, 5'b00000, 3'd0, 3'd0, 3'd3, 3'd0, 3'd3, 5'b11111);
        #1; check_all("bp_head", 3'd7, 3'd7, 3'd7, 3'd2, 3'd7, 5'b00100);
        @(negedge clk);
        drive(5'b10100, 5'b10000, 5'b10000, 3'd0, 3'd0, 3'd3, 3'd0, 3'd3, 5'b10111);
        #1; check_all("bp_stall1", 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 5'b00000);
        @(negedge clk); #1; check_all("bp_stall2", 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 5'b00000);
        @(negedge clk);
        drive(5'b10100, 5'b10000, 5'b10000, 3'd0, 3'd0, 3'd3, 3'd0, 3'd3, 5'b11111);
        #1; check_all("bp_resume", 3'd7, 3'd7, 3'd7, 3'd2, 3'd7, 5'b00100);
        @(negedge clk);
        drive(5'b10100, 5'b10000, 5'b10100, 3'd0, 3'd0, 3'd3, 3'd0, 3'd3, 5'b11111);
        #1; check_all("bp_tail", 3'd7, 3'd7, 3'd7, 3'd2, 3'd7, 5'b00100);
        @(negedge clk);
        drive(5'b10000, 5'b10000, 5'b10000, 3'd0, 3'd0, 3'd3, 3'd0, 3'd3, 5'b11111);
        #1; check_all("bp_after", 3'd7, 3'd7, 3'd7, 3'd4, 3'd7, 5'b10000);

        // Parallel non-conflicting traffic including an EJ U-turn.
        @(negedge clk);
        drive(5'b11111, 5'b11111, 5'b11111, 3'd1, 3'd0, 3'd3, 3'd2, 3'd4, 5'b11111);
        #1; check_all("parallel", 3'd1, 3'd0, 3'd3, 3'd2, 3'd4, 5'b11111);

        // Ignored requests: out-of-range dest and a body flit to unlocked U.
        @(negedge clk);
        drive(5'b00011, 5'b00001, 5'b00001, 3'd6, 3'd2, 3'd0, 3'd0, 3'd0, 5'b11111);
        #1; check_all("ignored", 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 5'b00000);
        // U pointer still sits after input D (4), so R wins over L, and no lock to L formed.
        @(negedge clk);
        drive(5'b00011, 5'b00011, 5'b00011, 3'd2, 3'd2, 3'd0, 3'd0, 3'd0, 5'b11111);
        #1; check_all("ignored_after", 3'd7, 3'd7, 3'd0, 3'd7, 3'd7, 5'b00001);

        // Async reset mid-packet: L locks R, then reset drops in the middle of a cycle.
        @(negedge clk);
        drive(5'b00010, 5'b00010, 5'b00000, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 5'b11111);
        #1; check_all("mr_head", 3'd1, 3'd7, 3'd7, 3'd7, 3'd7, 5'b00010);
        @(negedge clk);
        drive(5'b00110, 5'b00100, 5'b00100, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 5'b11111);
        #1; check_all("mr_body", 3'd1, 3'd7, 3'd7, 3'd7, 3'd7, 5'b00010);
        #1; rst_n = 1'b0;
        #1; check_all("mr_reset", 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 5'b00000);
        @(negedge clk);
        rst_n = 1'b1;
        #1; check_all("mr_release", 3'd2, 3'd7, 3'd7, 3'd7, 3'd7, 5'b00100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
